// File: rtl/mem_pkg.sv
// Memory-side encodings shared by the load aligner and the store byte-enable logic,
// so both paths always agree on the access-size encoding.
package mem_pkg;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'h0,
      MEM_HALF = 2'h1,
      MEM_WORD = 2'h2
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } la_state_t;

endpackage

// File: rtl/load_extract.sv
// Pure combinational lane select plus sign/zero extension of a little-endian
// 32-bit read word; shared by any load path that needs sub-word results.
module load_extract
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  mem_size_t   size,
   input  logic        sign,
   output logic [31:0] data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = 8'(rdata >> {addr_lo, 3'b000});
      // Halfword lane ignores addr_lo[0]: a misaligned half quietly reads the aligned one.
      half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         MEM_BYTE: data = {{24{sign & byte_lane[7]}}, byte_lane};
         MEM_HALF: data = {{16{sign & half_lane[15]}}, half_lane};
         default:  data = rdata;
      endcase
   end

endmodule

// File: rtl/load_aligner.sv
// Issues one data-memory read per load request, then returns the extracted and
// extended result, or an error response if memory stays silent too long.
module load_aligner
   import mem_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_addr_lo,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   output logic        mem_rd_en,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic        busy
);

   localparam int CW = $clog2(TIMEOUT + 1);

   la_state_t   state, state_nx;
   logic [CW-1:0] count, count_nx;
   logic [1:0]  addr_q;
   mem_size_t   size_q;
   logic        signed_q;
   logic [31:0] ext_data;
   logic        accept, load_rsp, load_err, clear_rsp;

   load_extract u_extract (
      .rdata   (mem_rdata),
      .addr_lo (addr_q),
      .size    (size_q),
      .sign    (signed_q),
      .data    (ext_data)
   );

   assign req_ready = (state == IDLE) | ((state == RESP) & rsp_ready);
   assign busy      = (state != IDLE);

   // Next-state decisions; rvalid wins over the timeout when both land on the same edge.
   always_comb begin
      state_nx  = state;
      count_nx  = count;
      load_rsp  = 1'b0;
      load_err  = 1'b0;
      clear_rsp = 1'b0;
      accept    = req_valid & req_ready;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nx = WAIT;
               count_nx = '0;
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               state_nx = RESP;
               load_rsp = 1'b1;
            end else begin
               count_nx = count + 1'b1;
               if (count == CW'(TIMEOUT - 1)) begin
                  state_nx = RESP;
                  load_err = 1'b1;
               end
            end
         end
         RESP: begin
            if (rsp_ready) begin
               clear_rsp = 1'b1;
               state_nx  = req_valid ? WAIT : IDLE;
               count_nx  = '0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         count     <= '0;
         addr_q    <= '0;
         size_q    <= MEM_WORD;
         signed_q  <= 1'b0;
         mem_rd_en <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_nx;
         count     <= count_nx;
         mem_rd_en <= accept;
         if (accept) begin
            addr_q   <= req_addr_lo;
            size_q   <= (req_size == 2'd3) ? MEM_WORD : mem_size_t'(req_size);
            signed_q <= req_signed;
         end
         if (load_rsp) begin
            rsp_data  <= ext_data;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
         end else if (load_err) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
         end else if (clear_rsp) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_load_aligner.sv
// Self-checking bench for load_aligner: directed corner cases plus randomized loads
// compared against an arithmetic model of byte/half/word extraction.
module tb_load_aligner;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_addr_lo = '0;
   logic [1:0]  req_size = '0;
   logic        req_signed = 1'b0;
   logic        mem_rd_en;
   logic [31:0] mem_rdata = '0;
   logic        mem_rvalid = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   load_aligner #(.TIMEOUT(TO)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr_lo (req_addr_lo),
      .req_size    (req_size),
      .req_signed  (req_signed),
      .mem_rd_en   (mem_rd_en),
      .mem_rdata   (mem_rdata),
      .mem_rvalid  (mem_rvalid),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_err     (rsp_err),
      .busy        (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Reference extraction from plain arithmetic: shift, modulo, two's-complement wrap.
   function automatic logic [31:0] model(input logic [31:0] rdata, input int addr,
                                         input int size, input bit sgn);
      longint v;
      if (size == 0) begin
         v = longint'(rdata >> (8 * addr)) % 256;
         if (sgn && v >= 128) v = v - 256;
      end else if (size == 1) begin
         v = longint'(rdata >> (16 * (addr / 2))) % 65536;
         if (sgn && v >= 32768) v = v - 65536;
      end else begin
         v = longint'(rdata);
      end
      return v[31:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one request (from IDLE or RESP), models memory with the given delay
   // (delay >= TO means memory never answers), then holds the response for 'hold' cycles.
   task automatic run_load(input int addr, input int size, input bit sgn,
                           input logic [31:0] rdata, input int delay, input int hold);
      logic [31:0] exp;
      logic [31:0] data0;
      bit          err;
      int          lat, explat, pulses;
      err    = (delay >= TO);
      explat = err ? TO : delay + 1;
      exp    = err ? 32'h0 : model(rdata, addr, size, sgn);
      req_valid   = 1'b1;
      req_addr_lo = addr[1:0];
      req_size    = size[1:0];
      req_signed  = sgn;
      rsp_ready   = 1'b1;
      mem_rvalid  = 1'b0;
      #1;
      check("req_ready_pre", 32'(req_ready), 32'd1);
      tick();
      req_valid   = 1'b0;
      rsp_ready   = 1'b0;
      req_addr_lo = 2'($urandom);
      req_size    = 2'($urandom);
      req_signed  = 1'($urandom);
      #1;
      check("strobe", 32'(mem_rd_en), 32'd1);
      check("busy_wait", 32'(busy), 32'd1);
      check("req_ready_wait", 32'(req_ready), 32'd0);
      check("rsp_valid_wait", 32'(rsp_valid), 32'd0);
      lat = 0;
      pulses = 1;
      while (!rsp_valid && lat < 12) begin
         mem_rvalid = (lat == delay);
         mem_rdata  = (lat == delay) ? rdata : $urandom;
         tick();
         lat++;
         if (mem_rd_en) pulses++;
      end
      mem_rvalid = 1'b0;
      check("latency", 32'(lat), 32'(explat));
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_data", rsp_data, exp);
      check("rsp_err", 32'(rsp_err), 32'(err));
      check("strobe_count", 32'(pulses), 32'd1);
      data0 = rsp_data;
      for (int i = 0; i < hold; i++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = $urandom;
         tick();
         check("hold_valid", 32'(rsp_valid), 32'd1);
         check("hold_data", rsp_data, data0);
         check("hold_err", 32'(rsp_err), 32'(err));
         check("hold_req_ready", 32'(req_ready), 32'd0);
      end
      mem_rvalid = 1'b0;
   endtask

   task automatic release_rsp();
      rsp_ready = 1'b1;
      req_valid = 1'b0;
      #1;
      check("req_ready_resp", 32'(req_ready), 32'd1);
      tick();
      rsp_ready = 1'b0;
      #1;
      check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_strobe", 32'(mem_rd_en), 32'd0);
   endtask

   initial begin
      #3;
      check("rst_rd_en", 32'(mem_rd_en), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      tick();
      reset_n = 1'b1;
      tick();

      // Stale rvalid while idle must be ignored.
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEADBEEF;
      tick();
      mem_rvalid = 1'b0;
      check("idle_rvalid_busy", 32'(busy), 32'd0);
      check("idle_rvalid_rsp", 32'(rsp_valid), 32'd0);

      run_load(3, 0, 1'b1, 32'h80123456, 2, 0);
      check("byte_signed_value", rsp_data, 32'hFFFFFF80);
      release_rsp();

      run_load(2, 1, 1'b0, 32'hBEEF0000, 1, 0);
      check("half_a2", rsp_data, 32'h0000BEEF);
      release_rsp();
      run_load(3, 1, 1'b0, 32'hBEEF0000, 0, 0);
      check("half_a3", rsp_data, 32'h0000BEEF);
      release_rsp();

      run_load(1, 2, 1'b1, 32'hA5C3F00F, 0, 3);
      check("word_value", rsp_data, 32'hA5C3F00F);

      // Back-to-back: next request accepted straight out of RESP.
      run_load(0, 0, 1'b0, 32'h123456F0, 1, 0);
      run_load(2, 1, 1'b1, 32'h8001FFFF, 3, 1);
      release_rsp();

      // Timeout, with late rvalid during the held response.
      run_load(0, 2, 1'b0, 32'h11111111, TO + 1, 2);
      check("timeout_data", rsp_data, 32'h0);
      check("timeout_err", 32'(rsp_err), 32'd1);
      release_rsp();

      // Reset mid-WAIT.
      req_valid   = 1'b1;
      req_addr_lo = 2'd0;
      req_size    = 2'd2;
      tick();
      req_valid = 1'b0;
      tick();
      reset_n = 1'b0;
      #1;
      check("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
      check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("mid_rst_rsp_data", rsp_data, 32'd0);
      check("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      #2;
      reset_n = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hCAFEF00D;
      tick();
      mem_rvalid = 1'b0;
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_rsp", 32'(rsp_valid), 32'd0);
      run_load(1, 0, 1'b0, 32'h0000AB00, 0, 0);
      check("post_rst_value", rsp_data, 32'h000000AB);
      release_rsp();

      for (int n = 0; n < 40; n++) begin
         run_load(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  1'($urandom), $urandom, int'($urandom_range(0, 5)),
                  int'($urandom_range(0, 2)));
         if ($urandom_range(0, 1) == 1) release_rsp();
      end
      release_rsp();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
